// File: rtl/dht11_scan_display.sv
// dht11_scan_display: round-robin scanner for N_CH DHT11 cores with per-channel result storage and LED readout.
// Define DHT11_SCAN_ERR_CNT_EN to add saturating per-channel failure counters shown via I_SHOW_ERR.
`timescale 1ns/1ps
module dht11_scan_display #(
   parameter int N_CH       = 4,
   parameter int BYTE_SZ    = 8,
   parameter int VALUE_SZ   = 16,
   parameter int PERIOD_CYC = 100000000,
   parameter int ACK_TO     = 1000,
   parameter int CONV_TO    = 2500000
) (
   input  logic                     CLK,
   input  logic                     RST_n,
   input  logic                     I_KEY_START,
   input  logic [3:0]               I_CH_SEL,
   input  logic                     I_BYTE_SEL,
   input  logic                     I_SHOW_ERR,
   input  logic [N_CH-1:0]          I_BUSY,
   input  logic [N_CH-1:0]          I_ERR,
   input  logic [N_CH*VALUE_SZ-1:0] I_VALUE,
   output logic [N_CH-1:0]          O_EN,
   output logic [N_CH-1:0]          O_VALID,
   output logic                     O_SCAN_BUSY,
   output logic                     O_DONE,
   output logic [9:0]               O_LEDR
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, STORE, NEXT} state_t;
   state_t r_state, w_next;
   logic [CW-1:0]       r_ch;
   logic [31:0]         r_to_cnt;
   logic                r_key_meta, r_key_sync, r_key_prev, r_pend, r_tout;
   logic [VALUE_SZ-1:0] r_val [N_CH];
   logic [N_CH-1:0]     r_err, r_valid;
   logic [9:0]          r_led;
   logic                w_key_req, w_tmr_req, w_req, w_last, w_timeout, w_ok, w_sel_err;
   logic [VALUE_SZ-1:0] w_sel_val;
   logic [7:0]          w_byte;

   assign w_key_req = r_key_prev & ~r_key_sync;
   assign w_req     = w_key_req | w_tmr_req;
   assign w_last    = (r_ch == CW'(N_CH - 1));
   assign w_ok      = ~r_tout & ~I_ERR[r_ch];

   generate
      if (PERIOD_CYC > 0) begin : g_tmr
         logic [31:0] r_per_cnt;
         always_ff @(posedge CLK or negedge RST_n)
            if (!RST_n) r_per_cnt <= '0;
            else r_per_cnt <= w_tmr_req ? '0 : r_per_cnt + 1'b1;
         assign w_tmr_req = (r_per_cnt == 32'(PERIOD_CYC - 1));
      end else begin : g_no_tmr
         assign w_tmr_req = 1'b0;
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST_n)
      if (!RST_n) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      case (r_state)
         IDLE:      if (w_req) w_next = START;
         START:     w_next = WAIT_ACK;
         WAIT_ACK:  if (I_BUSY[r_ch]) w_next = WAIT_DONE;
                    else if (r_to_cnt >= 32'(ACK_TO - 1)) begin w_next = STORE; w_timeout = 1'b1; end
         WAIT_DONE: if (!I_BUSY[r_ch]) w_next = STORE;
                    else if (r_to_cnt >= 32'(CONV_TO - 1)) begin w_next = STORE; w_timeout = 1'b1; end
         STORE:     w_next = NEXT;
         NEXT:      w_next = (!w_last || r_pend || w_req) ? START : IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n)
      if (!RST_n) begin
         {r_key_meta, r_key_sync, r_key_prev, r_pend, r_tout} <= '0;
         r_ch     <= '0;
         r_to_cnt <= '0;
         r_err    <= '0;
         r_valid  <= '0;
         r_led    <= '0;
         for (int k = 0; k < N_CH; k++) r_val[k] <= '0;
      end else begin
         {r_key_prev, r_key_sync, r_key_meta} <= {r_key_sync, r_key_meta, I_KEY_START};
         r_to_cnt <= (r_state != w_next) ? '0 : r_to_cnt + 1'b1;
         r_tout   <= w_timeout;
         r_pend   <= (r_state == IDLE || (r_state == NEXT && w_last)) ? 1'b0 : r_pend | w_req;
         if (r_state == IDLE) r_ch <= '0;
         else if (r_state == NEXT) r_ch <= w_last ? '0 : r_ch + 1'b1;
         if (r_state == STORE && w_ok) begin
            r_val[r_ch]   <= I_VALUE[r_ch*VALUE_SZ +: VALUE_SZ];
            r_valid[r_ch] <= 1'b1;
            r_err[r_ch]   <= 1'b0;
         end else if (r_state == STORE) r_err[r_ch] <= 1'b1;
         r_led <= {w_sel_err, r_state != IDLE, w_byte};
      end

   // Out-of-range channel selects fall through to zero.
   always_comb begin
      w_sel_val = '0;
      w_sel_err = 1'b0;
      for (int k = 0; k < N_CH; k++)
         if (I_CH_SEL == 4'(k)) begin
            w_sel_val = r_val[k];
            w_sel_err = r_err[k];
         end
   end

`ifdef DHT11_SCAN_ERR_CNT_EN
   logic [7:0] r_ecnt [N_CH];
   logic [7:0] w_sel_cnt;
   always_ff @(posedge CLK or negedge RST_n)
      if (!RST_n) for (int k = 0; k < N_CH; k++) r_ecnt[k] <= '0;
      else if (r_state == STORE && !w_ok && r_ecnt[r_ch] != 8'hFF) r_ecnt[r_ch] <= r_ecnt[r_ch] + 1'b1;
   always_comb begin
      w_sel_cnt = '0;
      for (int k = 0; k < N_CH; k++)
         if (I_CH_SEL == 4'(k)) w_sel_cnt = r_ecnt[k];
   end
   assign w_byte = I_SHOW_ERR ? w_sel_cnt :
                   I_BYTE_SEL ? 8'(w_sel_val[BYTE_SZ +: BYTE_SZ]) : 8'(w_sel_val[BYTE_SZ-1:0]);
`else
   logic w_unused;
   assign w_unused = I_SHOW_ERR;
   assign w_byte   = I_BYTE_SEL ? 8'(w_sel_val[BYTE_SZ +: BYTE_SZ]) : 8'(w_sel_val[BYTE_SZ-1:0]);
`endif

   assign O_EN        = (r_state == START) ? (N_CH'(1'b1) << r_ch) : '0;
   assign O_VALID     = r_valid;
   assign O_SCAN_BUSY = (r_state != IDLE);
   assign O_DONE      = (r_state == NEXT) && w_last;
   assign O_LEDR      = r_led;
endmodule

// File: tb/tb_dht11_scan_display.sv
// tb_dht11_scan_display: directed bench with DHT11 core models for a key-driven (no timer) and a timer-driven instance.
`timescale 1ns/1ps
module tb_dht11_scan_display;
   logic clk = 0, rst = 0, rst_t = 0, key = 1, key_t = 1, byte_sel = 0, show_err = 0;
   logic [3:0] ch_sel = 4'd2, errs = 4'd0, noack = 4'd0, zero4 = 4'd0, prev_en = 4'd0;
   logic [3:0] en_m, en_t, busy_m, busy_t, valid_m, valid_t;
   logic sb_m, sb_t, done_m, done_t;
   logic [9:0] led_m, led_t, exp100, expsat;
   logic [15:0] vals [4];
   logic [63:0] vbus;
   int mc_m [4], mc_t [4];
   int checks = 0, failures = 0, done_cnt = 0, done_t_cnt = 0, bad_en = 0;
   logic [3:0] en_log [$];

   always #5 clk = ~clk;
   assign vbus = {vals[3], vals[2], vals[1], vals[0]};

   dht11_scan_display #(.N_CH(4), .BYTE_SZ(8), .VALUE_SZ(16), .PERIOD_CYC(0), .ACK_TO(8), .CONV_TO(50)) dut (
      .CLK(clk), .RST_n(rst), .I_KEY_START(key), .I_CH_SEL(ch_sel), .I_BYTE_SEL(byte_sel),
      .I_SHOW_ERR(show_err), .I_BUSY(busy_m), .I_ERR(errs), .I_VALUE(vbus), .O_EN(en_m),
      .O_VALID(valid_m), .O_SCAN_BUSY(sb_m), .O_DONE(done_m), .O_LEDR(led_m));

   dht11_scan_display #(.N_CH(4), .BYTE_SZ(8), .VALUE_SZ(16), .PERIOD_CYC(200), .ACK_TO(8), .CONV_TO(50)) dut_t (
      .CLK(clk), .RST_n(rst_t), .I_KEY_START(key_t), .I_CH_SEL(ch_sel), .I_BYTE_SEL(byte_sel),
      .I_SHOW_ERR(show_err), .I_BUSY(busy_t), .I_ERR(zero4), .I_VALUE(vbus), .O_EN(en_t),
      .O_VALID(valid_t), .O_SCAN_BUSY(sb_t), .O_DONE(done_t), .O_LEDR(led_t));

   // Core model: busy rises 2 cycles after the start pulse and stays high 20 cycles.
   always @(posedge clk)
      for (int k = 0; k < 4; k++) begin
         if (en_m[k]) mc_m[k] <= 1;
         else if (mc_m[k] > 0 && mc_m[k] < 22) mc_m[k] <= mc_m[k] + 1;
         if (en_t[k]) mc_t[k] <= 1;
         else if (mc_t[k] > 0 && mc_t[k] < 22) mc_t[k] <= mc_t[k] + 1;
      end

   always_comb
      for (int k = 0; k < 4; k++) begin
         busy_m[k] = !noack[k] && mc_m[k] >= 2 && mc_m[k] < 22;
         busy_t[k] = mc_t[k] >= 2 && mc_t[k] < 22;
      end

   always @(negedge clk) begin
      if (en_m != 0) begin
         en_log.push_back(en_m);
         if ($countones(en_m) != 1 || en_m == prev_en) bad_en++;
      end
      prev_en = en_m;
      if (done_m) done_cnt++;
      if (done_t) done_t_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int target, input string tag);
      int n = 0;
      while (done_cnt < target && n < 300) begin tick(1); n++; end
      chk(tag, done_cnt, target);
   endtask

   task automatic wait_en(input logic [3:0] v, input string tag, output int n);
      n = 0;
      while (en_m !== v && n < 200) begin tick(1); n++; end
      chk(tag, en_m, v);
   endtask

   task automatic press();
      key = 1;
      tick(4);
      key = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
`ifdef DHT11_SCAN_ERR_CNT_EN
      exp100 = 10'h264;
      expsat = 10'h2FF;
`else
      exp100 = 10'h255;
      expsat = 10'h255;
`endif
      vals[0] = 16'h0A55; vals[1] = 16'h1234; vals[2] = 16'h3A17; vals[3] = 16'h5678;
      tick(3);
      chk("rst_en", en_m, 0);
      chk("rst_valid", valid_m, 0);
      chk("rst_led", led_m, 0);
      chk("rst_busy_done", {sb_m, done_m}, 0);
      rst = 1;
      tick(5);
      chk("idle_busy", sb_m, 0);
      // normal scan
      key = 0;
      wait_en(4'b0001, "en_ch0", n);
      chk("scan_busy", sb_m, 1);
      wait_en(4'b1000, "en_ch3", n);
      tick(3);
      chk("led_scanning", led_m, 10'h117);
      wait_done(1, "done1");
      tick(2);
      chk("led_after", led_m, 10'h017);
      chk("valid_all", valid_m, 4'hF);
      chk("en_order", {en_log[3], en_log[2], en_log[1], en_log[0]}, 16'h8421);
      chk("en_count", en_log.size(), 4);
      chk("en_onehot", bad_en, 0);
      byte_sel = 1;
      tick(2);
      chk("led_hi_byte", led_m, 10'h03A);
      // ack timeout on ch1
      noack[1] = 1; vals[1] = 16'hBEEF; ch_sel = 1; byte_sel = 0;
      press();
      wait_en(4'b0010, "to_en1", n);
      wait_en(4'b0100, "to_en2", n);
      chk("ack_to_gap", (n >= 8 && n <= 14), 1);
      wait_done(2, "done2");
      tick(2);
      chk("to_led_lo", led_m, 10'h234);
      chk("to_valid", valid_m, 4'hF);
      byte_sel = 1;
      tick(2);
      chk("to_led_hi", led_m, 10'h212);
      // core error on ch3
      noack[1] = 0; errs[3] = 1; vals[3] = 16'hFFFF; byte_sel = 0;
      press();
      wait_done(3, "done3");
      tick(2);
      chk("ch1_recovered", led_m, 10'h0EF);
      ch_sel = 3;
      tick(2);
      chk("ch3_err_kept", led_m, 10'h278);
      chk("err_valid", valid_m, 4'hF);
      errs[3] = 0; vals[3] = 16'h9ABC;
      press();
      wait_done(4, "done4");
      tick(2);
      chk("ch3_err_clear", led_m, 10'h0BC);
      ch_sel = 4'd9;
      tick(2);
      chk("ch_out_range", led_m, 10'h000);
      // no timer: nothing happens without a key edge
      en_log.delete();
      tick(300);
      chk("no_auto_en", en_log.size(), 0);
      chk("no_auto_done", done_cnt, 4);
      // reset mid-scan in WAIT_DONE on ch1
      ch_sel = 1;
      press();
      wait_en(4'b0010, "rst_en1", n);
      tick(5);
      chk("pre_rst_busy", sb_m, 1);
      rst = 0;
      #1;
      chk("rst_async", {en_m, valid_m, sb_m, done_m, led_m}, 0);
      tick(2);
      rst = 1;
      en_log.delete();
      tick(100);
      chk("no_en_after_rst", en_log.size(), 0);
      // error counter saturation on ch0
      press();
      wait_done(5, "done5");
      ch_sel = 0;
      tick(2);
      chk("ch0_good", led_m, 10'h055);
      noack[0] = 1; show_err = 1;
      for (int i = 0; i < 300; i++) begin
         press();
         wait_done(6 + i, "fail_scan_done");
         if (i == 99 || i == 255 || i == 299) begin
            tick(2);
            chk("err_cnt_led", led_m, (i == 99) ? exp100 : expsat);
         end
      end
      noack[0] = 0; show_err = 0;
      // timer instance: pending key and timer wrap during one scan
      rst_t = 1;
      tick(150);
      chk("t_no_scan_yet", {sb_t, 4'(done_t_cnt)}, 0);
      key_t = 0;
      tick(20);
      key_t = 1;
      tick(10);
      key_t = 0;
      n = 0;
      while (done_t_cnt < 1 && n < 200) begin tick(1); n++; end
      chk("t_done1", done_t_cnt, 1);
      chk("t_back_to_back", {sb_t, en_t}, 5'b1_0001);
      tick(120);
      chk("t_one_extra", done_t_cnt, 2);
      chk("t_idle", sb_t, 0);
      tick(140);
      chk("t_auto_scan", done_t_cnt, 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
